// File: rtl/gb_bus_pkg.sv
// Shared constants and types for the system bus arbiter and its OAM DMA sequencer.
//   ADDR_DMA_REG : CPU address of the DMA source-page register
//   HI_PAGE      : upper address byte of the high page (never blocked by DMA)
//   DMA_PAGE_MAX : highest source page used as-is; higher pages fold down by 0x20
package gb_bus_pkg;

    localparam logic [15:0] ADDR_DMA_REG = 16'hFF46;
    localparam logic [7:0]  HI_PAGE      = 8'hFF;
    localparam logic [7:0]  DMA_PAGE_MAX = 8'hDF;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaStart,
        DmaXfer
    } dma_state_e;

    typedef enum logic {
        OwnerCpu,
        OwnerDma
    } bus_owner_e;

endpackage

// File: rtl/sys_bus_arbiter_if.sv
// Main system bus seen by the arbiter.
//   bus_addr/bus_enable/bus_write/bus_wdata : driven by the arbiter (master)
//   bus_rdata                               : returned by the memory side (slave)
interface sys_bus_arbiter_if;

    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr,
        output bus_enable,
        output bus_write,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_enable,
        input  bus_write,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: holds the source-page register, the DMA FSM and byte index,
// and drives the OAM write port.
//   commit           : last clk of the M-cycle (t_cycle==3); all state moves here
//   reg_wr/reg_wdata : CPU write to the source-page register
//   bus_rdata        : main bus read data, forwarded to OAM on each transfer
//   src_page         : current register value (CPU read-back)
//   dma_xfer         : sequencer is driving dma_addr onto the main bus this M-cycle
//   dma_active       : DMA owns the main bus
//   oam_*            : OAM write port, strobe one clk wide at commit
module oam_dma_seq
    import gb_bus_pkg::*;
#(
    parameter int unsigned DMA_LEN         = 160,
    parameter int unsigned DMA_START_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        commit,
    input  logic        reg_wr,
    input  logic [7:0]  reg_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  src_page,
    output logic        dma_xfer,
    output logic [15:0] dma_addr,
    output logic        dma_active,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_wdata
);

    localparam logic [7:0] IDX_LAST   = 8'(DMA_LEN - 1);
    localparam logic [7:0] DELAY_LAST = 8'(DMA_START_DELAY - 1);
    // With no start delay a register write goes straight to transferring.
    localparam dma_state_e START_STATE = (DMA_START_DELAY == 0) ? DmaXfer : DmaStart;

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] delay_q, delay_d;
    logic [7:0] src_page_q, src_page_d;
    logic       restart_q, restart_d;
    logic [7:0] eff_page;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DmaIdle;
            idx_q      <= '0;
            delay_q    <= '0;
            src_page_q <= '0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            delay_q    <= delay_d;
            src_page_q <= src_page_d;
            restart_q  <= restart_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        delay_d    = delay_q;
        src_page_d = src_page_q;
        restart_d  = restart_q;
        if (commit) begin
            unique case (state_q)
                DmaStart: begin
                    if (delay_q == DELAY_LAST) begin
                        state_d = DmaXfer;
                        idx_d   = '0;
                    end else begin
                        delay_d = delay_q + 8'd1;
                    end
                end
                DmaXfer: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DmaIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
                default: ;
            endcase
            // A register write overrides the step above; the byte of the
            // current M-cycle has already been strobed into OAM.
            if (reg_wr) begin
                src_page_d = reg_wdata;
                state_d    = START_STATE;
                idx_d      = '0;
                delay_d    = '0;
                // Bus stays held through the delay only if it was already held.
                restart_d  = (state_q == DmaXfer) || ((state_q == DmaStart) && restart_q);
            end
        end
    end

    // Pages above 0xDF fold down onto work RAM (echo region).
    assign eff_page   = (src_page_q > DMA_PAGE_MAX) ? (src_page_q - 8'h20) : src_page_q;
    assign src_page   = src_page_q;
    assign dma_xfer   = (state_q == DmaXfer);
    assign dma_addr   = dma_xfer ? {eff_page, idx_q} : '0;
    assign dma_active = dma_xfer || ((state_q == DmaStart) && restart_q);
    assign oam_write  = dma_xfer && commit && !reset;
    assign oam_addr   = oam_write ? idx_q : '0;
    assign oam_wdata  = oam_write ? bus_rdata : '0;

endmodule

// File: rtl/sys_bus_arbiter.sv
// System bus arbiter between the CPU core, the main bus and the OAM DMA engine.
// Tracks the M-cycle phase, decodes CPU addresses and muxes main-bus ownership.
//   clk, reset            : system clock, synchronous active-high reset
//   cpu_*                 : CPU access request and read data
//   bus                   : main system bus (sys_bus_arbiter_if.master)
//   hi_*                  : high page 0xFF00-0xFFFF, offset only, never blocked
//   oam_*                 : OAM write port fed by the DMA engine
//   dma_active            : DMA owns the main bus
// Optional build macro DMA_BUS_CONFLICT_EN: a CPU main-bus read blocked by DMA
// returns the byte currently on the bus instead of 0xFF.
module sys_bus_arbiter
    import gb_bus_pkg::*;
#(
    parameter int unsigned DMA_LEN         = 160,
    parameter int unsigned DMA_START_DELAY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              cpu_addr,
    input  logic                     cpu_enable,
    input  logic                     cpu_write,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    sys_bus_arbiter_if.master        bus,
    output logic [7:0]               hi_addr,
    output logic                     hi_enable,
    output logic                     hi_write,
    output logic [7:0]               hi_wdata,
    input  logic [7:0]               hi_rdata,
    output logic [7:0]               oam_addr,
    output logic                     oam_write,
    output logic [7:0]               oam_wdata,
    output logic                     dma_active
);

    logic [1:0]  t_cycle_q, t_cycle_d;
    logic        commit;
    logic        is_dma_reg;
    logic        is_hi;
    logic        cpu_main;
    logic        cpu_hi;
    logic        reg_wr;
    logic [7:0]  src_page;
    logic        dma_xfer;
    logic [15:0] dma_addr;
    bus_owner_e  owner;

    // Same reset as the CPU core's counter, so both agree on the phase.
    always_ff @(posedge clk) begin
        if (reset) t_cycle_q <= '0;
        else       t_cycle_q <= t_cycle_d;
    end

    always_comb begin
        t_cycle_d = t_cycle_q + 2'd1;
    end

    assign commit     = (t_cycle_q == 2'd3);
    assign is_dma_reg = (cpu_addr == ADDR_DMA_REG);
    assign is_hi      = (cpu_addr[15:8] == HI_PAGE) && !is_dma_reg;
    assign cpu_hi     = cpu_enable && is_hi;
    assign cpu_main   = cpu_enable && (cpu_addr[15:8] != HI_PAGE);
    assign reg_wr     = cpu_enable && cpu_write && is_dma_reg;
    assign owner      = dma_active ? OwnerDma : OwnerCpu;

    oam_dma_seq #(
        .DMA_LEN         (DMA_LEN),
        .DMA_START_DELAY (DMA_START_DELAY)
    ) u_dma (
        .clk        (clk),
        .reset      (reset),
        .commit     (commit),
        .reg_wr     (reg_wr),
        .reg_wdata  (cpu_wdata),
        .bus_rdata  (bus.bus_rdata),
        .src_page   (src_page),
        .dma_xfer   (dma_xfer),
        .dma_addr   (dma_addr),
        .dma_active (dma_active),
        .oam_addr   (oam_addr),
        .oam_write  (oam_write),
        .oam_wdata  (oam_wdata)
    );

    // Main bus: DMA read, CPU pass-through, or idle (incl. restart delay).
    always_comb begin
        bus.bus_addr   = '0;
        bus.bus_enable = 1'b0;
        bus.bus_write  = 1'b0;
        bus.bus_wdata  = '0;
        if (dma_xfer) begin
            bus.bus_addr   = dma_addr;
            bus.bus_enable = 1'b1;
        end else if ((owner == OwnerCpu) && cpu_main) begin
            bus.bus_addr   = cpu_addr;
            bus.bus_enable = 1'b1;
            bus.bus_write  = cpu_write;
            bus.bus_wdata  = cpu_wdata;
        end
    end

    always_comb begin
        hi_addr   = '0;
        hi_enable = 1'b0;
        hi_write  = 1'b0;
        hi_wdata  = '0;
        if (cpu_hi) begin
            hi_addr   = cpu_addr[7:0];
            hi_enable = 1'b1;
            hi_write  = cpu_write;
            hi_wdata  = cpu_wdata;
        end
    end

    always_comb begin
        cpu_rdata = 8'hFF;
        if (cpu_enable) begin
            if (is_dma_reg) begin
                cpu_rdata = src_page;
            end else if (is_hi) begin
                cpu_rdata = hi_rdata;
            end else if (owner == OwnerCpu) begin
                cpu_rdata = bus.bus_rdata;
            end else begin
`ifdef DMA_BUS_CONFLICT_EN
                cpu_rdata = bus.bus_rdata;
`else
                cpu_rdata = 8'hFF;
`endif
            end
        end
    end

endmodule
